// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per clock, LSB first.
// Result and final borrow are registered on the last shift and held until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]  cnt;
    logic           bq;
    logic           d_bit, bq_nx, last;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bin);
        return {(~ai & bi) | (~(ai ^ bi) & bin), ai ^ bi ^ bin};
    endfunction

    assign {bq_nx, d_bit} = sub_bit(a_sh[0], b_sh[0], bq);
    assign last           = (cnt == LAST_CNT);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Control and visible results; the last SHIFT edge is the entry into DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            bq     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cnt <= '0;
                bq  <= 1'b0;
            end else if (state == SHIFT) begin
                cnt <= cnt + 1'b1;
                bq  <= bq_nx;
                if (last) begin
                    diff   <= {d_bit, res_sh[WIDTH-1:1]};
                    borrow <= bq_nx;
                end
            end
        end
    end

    // Operand and partial-result shifters carry no reset: every bit is rewritten before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {d_bit, res_sh[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Expected {borrow, diff} are queued when an operation is launched and compared when done pulses.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start8, start16;
    logic [7:0]  a8, b8, diff8;
    logic        busy8, done8, borrow8;
    logic [15:0] a16, b16, diff16;
    logic        busy16, done16, borrow16;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge with dut8 idle; operands are scrambled and start is toggled mid-operation.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int busy_n = 0;
        int guard  = 0;
        logic [8:0] e;
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back({a < b, 8'(a - b)});
        @(negedge clk);
        while (!done8 && guard < 40) begin
            if (busy8) busy_n++;
            a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        start8 = 1'b0;
        chk({tag, "_done"}, 32'(done8), 1);
        e = q8.pop_front();
        if (done8) begin
            if (busy8) busy_n++;
            chk({tag, "_diff"}, 32'(diff8), 32'(e[7:0]));
            chk({tag, "_borrow"}, 32'(borrow8), 32'(e[8]));
            chk({tag, "_busycycles"}, busy_n, 9);
        end
        @(negedge clk);
        chk({tag, "_donepulse"}, 32'(done8), 0);
        chk({tag, "_idle"}, 32'(busy8), 0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input string tag);
        int guard = 0;
        logic [16:0] e;
        a16 = a; b16 = b; start16 = 1'b1;
        q16.push_back({a < b, 16'(a - b)});
        @(negedge clk);
        start16 = 1'b0;
        while (!done16 && guard < 40) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            @(negedge clk);
            guard++;
        end
        chk({tag, "_done"}, 32'(done16), 1);
        e = q16.pop_front();
        if (done16) begin
            chk({tag, "_diff"}, 32'(diff16), 32'(e[15:0]));
            chk({tag, "_borrow"}, 32'(borrow16), 32'(e[16]));
        end
        @(negedge clk);
    endtask

    initial begin
        int guard, tprev, seen;
        logic [8:0] e;
        tprev = 0;

        rst_n = 1'b0; start8 = 1'b1; start16 = 1'b1;
        a8 = 8'h55; b8 = 8'h11; a16 = 16'h1234; b16 = 16'h0001;
        repeat (3) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_diff8", 32'(diff8), 0);
        chk("rst_borrow8", 32'(borrow8), 0);
        chk("rst_busy16", 32'(busy16), 0);
        chk("rst_diff16", 32'(diff16), 0);

        rst_n = 1'b1; start8 = 1'b0; start16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_hold", 32'(busy8), 0);

        op8(8'h05, 8'h03, "sub_05_03");
        op8(8'h03, 8'h05, "sub_03_05");
        op8(8'h00, 8'hFF, "sub_00_ff");
        op8(8'hA5, 8'hA5, "sub_a5_a5");
        op8(8'hFF, 8'h00, "sub_ff_00");
        op8(8'h00, 8'h00, "sub_00_00");
        op8(8'h80, 8'h81, "sub_80_81");

        // Start held high: a new result every 10 cycles, operands scrambled while busy.
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q8.push_back({1'b0, 8'h0F});
            guard = 0;
            @(negedge clk);
            while (!done8 && guard < 30) begin
                if (busy8) begin
                    a8 = 8'($urandom); b8 = 8'($urandom);
                end else begin
                    a8 = 8'h10; b8 = 8'h01;
                end
                @(negedge clk);
                guard++;
            end
            chk("cont_done", 32'(done8), 1);
            e = q8.pop_front();
            chk("cont_diff", 32'(diff8), 32'(e[7:0]));
            chk("cont_borrow", 32'(borrow8), 32'(e[8]));
            if (k > 0) chk("cont_period", cyc - tprev, 10);
            tprev = cyc;
            a8 = 8'h10; b8 = 8'h01;
            if (k == 3) start8 = 1'b0;
        end
        @(negedge clk);
        chk("cont_stop", 32'(busy8), 0);
        chk("cont_hold_diff", 32'(diff8), 32'h0F);

        // Abort four cycles into an operation, then restart on the first released cycle.
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        seen = 0;
        repeat (3) begin
            if (done8) seen++;
            @(negedge clk);
        end
        chk("abort_midop_diff", 32'(diff8), 32'h0F);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_nodone_before", seen, 0);
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_done", 32'(done8), 0);
        chk("abort_diff", 32'(diff8), 0);
        chk("abort_borrow", 32'(borrow8), 0);
        rst_n = 1'b1;
        op8(8'h80, 8'h7F, "restart_80_7f");

        for (int i = 0; i < 2000; i++) op8(8'($urandom), 8'($urandom), "sweep8");

        op16(16'h0000, 16'hFFFF, "w16_0_ffff");
        op16(16'hBEEF, 16'hBEEF, "w16_eq");
        for (int i = 0; i < 2000; i++) op16(16'($urandom), 16'($urandom), "sweep16");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
